sigrnd_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational significand rounder in the FPU rounder path.
- Rounds a (SIG_W+2)-bit pre-rounded significand (kept bits + round bit + sticky bit) in double or single format.
- Supports five rounding modes and carries a transaction tag.
- Uses a valid/ready handshake with per-stage bubble collapsing, and keeps a saturating count of inexact results for the FPU status logic.

---
 rtl/sigrnd_pipe_if.sv | 29 ++
 rtl/sigrnd_pipe.sv | 125 ++++++++++++
 tb/tb_sigrnd_pipe.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sigrnd_pipe_if.sv
// Handshake and data bundle for the pipelined significand rounder.
// The producer/consumer side takes the master modport, the rounder takes slave.
interface sigrnd_pipe_if #(
  parameter int SIG_W = 53,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             s;
  logic             db;
  logic [SIG_W+1:0] f1;
  logic [2:0]       rm;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [SIG_W:0]   f2;
  logic             siginx;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, s, db, f1, rm, tag_in, out_ready,
    input  in_ready, out_valid, f2, siginx, tag_out
  );

  modport slave (
    input  in_valid, s, db, f1, rm, tag_in, out_ready,
    output in_ready, out_valid, f2, siginx, tag_out
  );
endinterface

// File: rtl/sigrnd_pipe.sv
// Pipelined significand rounder: double/single format, five rounding modes,
// valid/ready handshake with bubble collapsing and a saturating inexact counter.
module sigrnd_pipe #(
  parameter int SIG_W  = 53,
  parameter int SGL_W  = 24,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sigrnd_pipe_if.slave     bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] inx_cnt
);

  localparam int DW  = SIG_W + 1;
  localparam int SW  = SGL_W + 1;
  localparam int PAD = SIG_W - SGL_W;

  typedef struct packed {
    logic [SIG_W:0]   f2;
    logic             inx;
    logic [TAG_W-1:0] tag;
  } pay_t;

  logic             k_lsb;
  logic             rbit;
  logic             sbit;
  logic             inc;
  logic [SIG_W:0]   sum_d;
  logic [SGL_W:0]   sum_s;
  pay_t             new_pay;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;
  pay_t              pay [STAGES];
  logic              full_tail;

  // Field extraction and increment decision; codes 101..111 fall back to RNE.
  always_comb begin
    k_lsb = 1'b0;
    rbit  = 1'b0;
    sbit  = 1'b0;
    inc   = 1'b0;
    if (bus.db) begin
      k_lsb = bus.f1[2];
      rbit  = bus.f1[1];
      sbit  = bus.f1[0];
    end else begin
      k_lsb = bus.f1[SIG_W+2-SGL_W];
      rbit  = bus.f1[SIG_W+1-SGL_W];
      sbit  = |bus.f1[SIG_W-SGL_W:0];
    end
    case (bus.rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = ~bus.s & (rbit | sbit);
      3'b011:  inc = bus.s & (rbit | sbit);
      3'b100:  inc = rbit;
      default: inc = rbit & (k_lsb | sbit);
    endcase
  end

  // Carry-out of either format lands in the result MSB; single results sit left-aligned.
  always_comb begin
    sum_d       = {1'b0, bus.f1[SIG_W+1:2]} + DW'(inc);
    sum_s       = {1'b0, bus.f1[SIG_W+1:SIG_W+2-SGL_W]} + SW'(inc);
    new_pay.f2  = bus.db ? sum_d : {sum_s, {PAD{1'b0}}};
    new_pay.inx = rbit | sbit;
    new_pay.tag = bus.tag_in;
  end

  // A stage can take new data unless it and every stage after it are full
  // while the consumer stalls; this keeps the only combinational path out_ready -> in_ready.
  always_comb begin
    full_tail = 1'b1;
    rdy       = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      full_tail = full_tail & vld[i];
      rdy[i]    = ~full_tail | bus.out_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        pay[i] <= '0;
      end
    end else begin
      if (rdy[0]) begin
        vld[0] <= bus.in_valid;
        if (bus.in_valid) begin
          pay[0] <= new_pay;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            pay[i] <= pay[i-1];
          end
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.f2        = pay[STAGES-1].f2;
  assign bus.siginx    = pay[STAGES-1].inx;
  assign bus.tag_out   = pay[STAGES-1].tag;

  // Clear wins over a coincident inexact handshake; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inx_cnt <= '0;
    end else if (cnt_clr) begin
      inx_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.siginx && (inx_cnt != '1)) begin
      inx_cnt <= inx_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sigrnd_pipe.sv
// Directed self-checking bench for sigrnd_pipe with hand-computed expectations.
module tb_sigrnd_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] inx_cnt;

  int testsRun  = 0;
  int failCount = 0;
  int expCnt    = 0;

  sigrnd_pipe_if #(.SIG_W(53), .TAG_W(4)) bus ();

  sigrnd_pipe #(
    .SIG_W(53), .SGL_W(24), .STAGES(2), .TAG_W(4), .CNT_W(16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .cnt_clr(cnt_clr),
    .inx_cnt(inx_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        db;
    logic [54:0] f1;
    logic [2:0]  rm;
    logic [53:0] f2;
    logic        inx;
  } vec_t;

  vec_t vecs [14] = '{
    '{1'b0, 1'b1, 55'h7,              3'd0, 54'h2,              1'b1},
    '{1'b0, 1'b1, 55'h2,              3'd0, 54'h0,              1'b1},
    '{1'b0, 1'b1, 55'h2,              3'd4, 54'h1,              1'b1},
    '{1'b0, 1'b1, 55'h2,              3'd1, 54'h0,              1'b1},
    '{1'b1, 1'b1, 55'h2,              3'd3, 54'h1,              1'b1},
    '{1'b1, 1'b1, 55'h2,              3'd2, 54'h0,              1'b1},
    '{1'b0, 1'b1, 55'h2,              3'd7, 54'h0,              1'b1},
    '{1'b0, 1'b1, 55'h6,              3'd0, 54'h2,              1'b1},
    '{1'b0, 1'b1, 55'hA,              3'd0, 54'h2,              1'b1},
    '{1'b0, 1'b1, 55'h7FFFFFFFFFFFFF, 3'd2, 54'h20000000000000, 1'b1},
    '{1'b0, 1'b1, 55'h7FFFFFFFFFFFFF, 3'd3, 54'h1FFFFFFFFFFFFF, 1'b1},
    '{1'b0, 1'b0, 55'h7FFFFFC0000000, 3'd0, 54'h20000000000000, 1'b1},
    '{1'b0, 1'b0, 55'h7FFFFF80000000, 3'd0, 54'h1FFFFFE0000000, 1'b0},
    '{1'b0, 1'b0, 55'h1,              3'd2, 54'h20000000,       1'b1}
  };

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, obs, exp);
    end
  endtask

  // Offer one transaction, wait for its result and consume it (optionally clearing the counter then).
  task automatic applyStimulus(input logic sv, input logic dbv, input logic [54:0] f1v,
                               input logic [2:0] rmv, input logic [3:0] tg, input logic clr,
                               output logic [53:0] of2, output logic oinx,
                               output logic [3:0] otag, output int lat);
    int n;
    bus.s        = sv;
    bus.db       = dbv;
    bus.f1       = f1v;
    bus.rm       = rmv;
    bus.tag_in   = tg;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("accept_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
    of2  = bus.f2;
    oinx = bus.siginx;
    otag = bus.tag_out;
    if (clr) cnt_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [53:0] rf2;
    logic        rinx;
    logic [3:0]  rtag;
    logic [53:0] heldF2;
    int          lat;
    int          stale;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.s         = 1'b0;
    bus.db        = 1'b1;
    bus.f1        = '0;
    bus.rm        = 3'd0;
    bus.tag_in    = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_f2", 64'(bus.f2), 64'd0);
    checkOutput("rst_cnt", 64'(inx_cnt), 64'd0);
    rst_n = 1'b1;
    #1 checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Directed rounding vectors.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].s, vecs[i].db, vecs[i].f1, vecs[i].rm, 4'(i), 1'b0, rf2, rinx, rtag, lat);
      expCnt += int'(vecs[i].inx);
      checkOutput($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
      checkOutput($sformatf("vec%0d_f2", i), 64'(rf2), 64'(vecs[i].f2));
      checkOutput($sformatf("vec%0d_inx", i), 64'(rinx), 64'(vecs[i].inx));
      checkOutput($sformatf("vec%0d_tag", i), 64'(rtag), 64'(i));
      checkOutput($sformatf("vec%0d_cnt", i), 64'(inx_cnt), 64'(expCnt));
    end

    // Backpressure: two fill the pipe, in_ready drops, outputs hold, then drain in order.
    bus.out_ready = 1'b0;
    bus.s  = 1'b0;
    bus.db = 1'b1;
    bus.rm = 3'd1;
    for (int t = 1; t <= 2; t++) begin
      bus.f1 = 55'(t) << 2;
      bus.tag_in = 4'(t);
      bus.in_valid = 1'b1;
      checkOutput($sformatf("bp_ready%0d", t), 64'(bus.in_ready), 64'd1);
      @(negedge clk);
    end
    bus.f1 = 55'd3 << 2;
    bus.tag_in = 4'd3;
    for (int c = 0; c < 3; c++) begin
      checkOutput("bp_full_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("bp_hold_tag", 64'(bus.tag_out), 64'd1);
      checkOutput("bp_hold_f2", 64'(bus.f2), 64'd1);
      @(negedge clk);
    end
    heldF2 = bus.f2;
    bus.out_ready = 1'b1;
    #1 checkOutput("bp_ready_release", 64'(bus.in_ready), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("bp_out%0d_valid", k), 64'(bus.out_valid), 64'd1);
      checkOutput($sformatf("bp_out%0d_tag", k), 64'(bus.tag_out), 64'(k));
      checkOutput($sformatf("bp_out%0d_f2", k), 64'(bus.f2), 64'(k));
      if (k == 1) begin
        checkOutput("bp_first_f2", 64'(heldF2), 64'd1);
      end else if (k == 2) begin
        bus.f1 = 55'd4 << 2;
        bus.tag_in = 4'd4;
      end else if (k == 3) begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("bp_drained", 64'(bus.out_valid), 64'd0);
    checkOutput("bp_cnt", 64'(inx_cnt), 64'(expCnt));

    // Counter: clear, 3 inexact + 1 exact, then clear racing an inexact handshake.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    checkOutput("cnt_clr_idle", 64'(inx_cnt), 64'd0);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 1'b1, 55'h7, 3'd0, 4'd9, 1'b0, rf2, rinx, rtag, lat);
    end
    applyStimulus(1'b0, 1'b1, 55'h4, 3'd0, 4'd10, 1'b0, rf2, rinx, rtag, lat);
    checkOutput("cnt_three", 64'(inx_cnt), 64'd3);
    applyStimulus(1'b0, 1'b1, 55'h7, 3'd0, 4'd11, 1'b1, rf2, rinx, rtag, lat);
    checkOutput("cnt_clr_priority", 64'(inx_cnt), 64'd0);

    // Reset with two transactions in flight.
    applyStimulus(1'b0, 1'b1, 55'h7, 3'd0, 4'd12, 1'b0, rf2, rinx, rtag, lat);
    checkOutput("pre_rst_cnt", 64'(inx_cnt), 64'd1);
    bus.out_ready = 1'b0;
    bus.f1 = 55'h7;
    bus.rm = 3'd0;
    bus.in_valid = 1'b1;
    bus.tag_in = 4'd13;
    @(negedge clk);
    bus.tag_in = 4'd14;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_async_cnt", 64'(inx_cnt), 64'd0);
    checkOutput("rst_async_tag", 64'(bus.tag_out), 64'd0);
    checkOutput("rst_async_inx", 64'(bus.siginx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1 checkOutput("rst_rel_ready", 64'(bus.in_ready), 64'd1);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    checkOutput("rst_no_stale", 64'(stale), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
